// File: rtl/rgmii_rx_sequencer.sv
// RGMII receive sequencer: turns DDR capture pairs into a preamble-stripped
// valid/last/err byte stream and keeps saturating frame/error statistics.
module rgmii_rx_sequencer #(
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [4:0]             q1_i,
    input  logic [4:0]             q2_i,
    input  logic [1:0]             speed_i,
    output logic [7:0]             data_o,
    output logic                   v_o,
    output logic                   last_o,
    output logic                   err_o,
    output logic [cnt_width_p-1:0] frame_cnt_o,
    output logic [cnt_width_p-1:0] err_cnt_o
);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_e;

    localparam logic [cnt_width_p-1:0] cnt_one = 1;

    state_e     state_r, state_n;

    logic       dv;
    logic       er;
    logic [7:0] rx_byte;
    logic [3:0] rx_nib;
    logic       gig_live;
    logic       is_pre;
    logic       is_sfd;
    logic       unused_speed;

    logic       gig_r, gig_n;
    logic [7:0] hold_r, hold_n;
    logic       hold_full_r, hold_full_n;
    logic       err_flag_r, err_flag_n;
    logic       nib_phase_r, nib_phase_n;
    logic [3:0] nib_lo_r, nib_lo_n;

    logic [7:0] data_n;
    logic       v_n, last_n, err_n;
    logic       byte_done;
    logic [7:0] new_byte;
    logic       frame_inc, err_inc;

    assign dv           = q1_i[4];
    assign er           = q1_i[4] ^ q2_i[4];
    assign rx_byte      = {q2_i[3:0], q1_i[3:0]};
    assign rx_nib       = q1_i[3:0];
    // Only bit 1 distinguishes DDR (2,3) from nibble (0,1) operation.
    assign gig_live     = speed_i[1];
    assign unused_speed = speed_i[0];
    assign is_pre       = gig_live ? (rx_byte == 8'h55) : (rx_nib == 4'h5);
    assign is_sfd       = gig_live ? (rx_byte == 8'hD5) : (rx_nib == 4'hD);

    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path through the case statement can infer a latch.
        state_n     = state_r;
        gig_n       = gig_r;
        hold_n      = hold_r;
        hold_full_n = hold_full_r;
        err_flag_n  = err_flag_r;
        nib_phase_n = nib_phase_r;
        nib_lo_n    = nib_lo_r;
        data_n      = data_o;
        v_n         = 1'b0;
        last_n      = 1'b0;
        err_n       = 1'b0;
        byte_done   = 1'b0;
        new_byte    = rx_byte;
        frame_inc   = 1'b0;
        err_inc     = 1'b0;

        case (state_r)
            IDLE: begin
                if (dv) state_n = is_pre ? PRE : DROP;
            end
            PRE: begin
                if (!dv) begin
                    state_n = IDLE;
                end else if (er) begin
                    state_n = DROP;
                end else if (is_sfd) begin
                    state_n     = DATA;
                    gig_n       = gig_live;
                    nib_phase_n = 1'b0;
                    hold_full_n = 1'b0;
                    err_flag_n  = 1'b0;
                end else if (!is_pre) begin
                    state_n = DROP;
                end
            end
            DATA: begin
                if (dv) begin
                    if (er) err_flag_n = 1'b1;
                    if (gig_r) begin
                        byte_done = 1'b1;
                    end else if (nib_phase_r) begin
                        byte_done   = 1'b1;
                        new_byte    = {rx_nib, nib_lo_r};
                        nib_phase_n = 1'b0;
                    end else begin
                        nib_lo_n    = rx_nib;
                        nib_phase_n = 1'b1;
                    end
                    // The hold stage delays each byte until we know whether it is the last.
                    if (byte_done) begin
                        hold_n      = new_byte;
                        hold_full_n = 1'b1;
                        if (hold_full_r) begin
                            data_n = hold_r;
                            v_n    = 1'b1;
                        end
                    end
                end else begin
                    state_n     = IDLE;
                    hold_full_n = 1'b0;
                    err_flag_n  = 1'b0;
                    nib_phase_n = 1'b0;
                    if (hold_full_r) begin
                        data_n    = hold_r;
                        v_n       = 1'b1;
                        last_n    = 1'b1;
                        err_n     = err_flag_r | (!gig_r & nib_phase_r);
                        frame_inc = !err_n;
                        err_inc   = err_n;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!dv) begin
                    state_n = IDLE;
                    err_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset_i) begin
            state_r     <= IDLE;
            gig_r       <= 1'b0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            err_flag_r  <= 1'b0;
            nib_phase_r <= 1'b0;
            nib_lo_r    <= '0;
            data_o      <= '0;
            v_o         <= 1'b0;
            last_o      <= 1'b0;
            err_o       <= 1'b0;
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            state_r     <= state_n;
            gig_r       <= gig_n;
            hold_r      <= hold_n;
            hold_full_r <= hold_full_n;
            err_flag_r  <= err_flag_n;
            nib_phase_r <= nib_phase_n;
            nib_lo_r    <= nib_lo_n;
            data_o      <= data_n;
            v_o         <= v_n;
            last_o      <= last_n;
            err_o       <= err_n;
            if (frame_inc && (frame_cnt_o != '1)) frame_cnt_o <= frame_cnt_o + cnt_one;
            if (err_inc && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + cnt_one;
        end
    end

endmodule

// File: tb/tb_rgmii_rx_sequencer.sv
// Scoreboard bench for rgmii_rx_sequencer: frame-level reference model feeds an
// expected-byte queue that a free-running monitor drains.
module tb_rgmii_rx_sequencer;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [4:0]    q1_i;
    logic [4:0]    q2_i;
    logic [1:0]    speed_i;
    logic [7:0]    data_o;
    logic          v_o;
    logic          last_o;
    logic          err_o;
    logic [CW-1:0] frame_cnt_o;
    logic [CW-1:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    rgmii_rx_sequencer #(.cnt_width_p(CW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .q1_i        (q1_i),
        .q2_i        (q2_i),
        .speed_i     (speed_i),
        .data_o      (data_o),
        .v_o         (v_o),
        .last_o      (last_o),
        .err_o       (err_o),
        .frame_cnt_o (frame_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       err;
    } exp_t;

    typedef logic [7:0] sym_q_t[$];

    exp_t       exp_q[$];
    int         n_vec    = 0;
    int         n_bad    = 0;
    int         m_frame  = 0;
    int         m_err    = 0;
    logic [7:0] mon_last = 8'h00;
    logic       mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    // Monitor: every byte presented must match the head of the expected queue;
    // between bytes data_o must hold and last/err must be low.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (v_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_v", 32'(v_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", {22'd0, data_o, last_o, err_o}, {22'd0, e.data, e.last, e.err});
                end
                mon_last = data_o;
            end else begin
                check("idle_out", {22'd0, data_o, last_o, err_o}, {22'd0, mon_last, 2'b00});
            end
        end
    end

    task automatic drive(input logic dv, input logic er, input logic [7:0] b, input logic [1:0] spd);
        @(negedge clk_i);
        q1_i    = {dv, b[3:0]};
        q2_i    = {dv ^ er, b[7:4]};
        speed_i = spd;
    endtask

    function automatic logic [7:0] pre_sym(input logic gig);
        return gig ? 8'h55 : {4'($urandom), 4'h5};
    endfunction

    // Good-path frame: npre preamble symbols, SFD, then syms (bytes at 1000M,
    // low nibbles at 10/100M), er on symbol er_idx, then gap idle cycles.
    task automatic send_frame(input logic [1:0] spd, input int npre, input sym_q_t syms,
                              input int er_idx, input int gap);
        logic gig;
        int   nbytes;
        logic bad;
        logic [7:0] d;
        gig    = spd[1];
        nbytes = gig ? syms.size() : syms.size() / 2;
        bad    = (er_idx >= 0 && er_idx < syms.size()) || (!gig && (syms.size() % 2 == 1));
        if (nbytes == 0) begin
            m_err = sat(m_err + 1);
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                d = gig ? syms[k] : {syms[2*k+1][3:0], syms[2*k][3:0]};
                exp_q.push_back('{data: d, last: (k == nbytes - 1), err: (k == nbytes - 1) && bad});
            end
            if (bad) m_err = sat(m_err + 1);
            else     m_frame = sat(m_frame + 1);
        end
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, pre_sym(gig), spd);
        drive(1'b1, 1'b0, gig ? 8'hD5 : {4'($urandom), 4'hD}, spd);
        for (int i = 0; i < syms.size(); i++)
            drive(1'b1, (i == er_idx), gig ? syms[i] : {4'($urandom), syms[i][3:0]}, 2'($urandom));
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'($urandom), 2'($urandom));
    endtask

    // Dropped frame: after npre preamble symbols, either a non-preamble/non-SFD
    // value or (use_er) a preamble value with er, then extra garbage symbols.
    task automatic send_bad(input logic [1:0] spd, input int npre, input logic use_er,
                            input int extra, input int gap);
        logic gig;
        logic [7:0] v;
        gig = spd[1];
        m_err = sat(m_err + 1);
        do v = 8'($urandom);
        while (gig ? (v == 8'h55 || v == 8'hD5) : (v[3:0] == 4'h5 || v[3:0] == 4'hD));
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, pre_sym(gig), spd);
        if (use_er) drive(1'b1, 1'b1, pre_sym(gig), spd);
        else        drive(1'b1, 1'b0, v, spd);
        for (int i = 0; i < extra; i++) drive(1'b1, 1'($urandom), 8'($urandom), 2'($urandom));
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'($urandom), 2'($urandom));
    endtask

    task automatic send_runt(input logic [1:0] spd, input int npre, input int gap);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, pre_sym(spd[1]), spd);
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'($urandom), 2'($urandom));
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'($urandom), 2'($urandom));
        @(posedge clk_i);
        #2;
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(m_frame));
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'(m_err));
    endtask

    initial begin
        sym_q_t q;
        logic [1:0] spd;
        int len;
        int kind;

        reset_i = 1'b1;
        q1_i    = '0;
        q2_i    = '0;
        speed_i = 2'd2;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outs", {22'd0, v_o, data_o, last_o}, 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check("reset_err_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        mon_en  = 1'b1;

        // 1000M, 64 bytes 0x01..0x40
        q = {};
        for (int i = 1; i <= 64; i++) q.push_back(8'(i));
        send_frame(2'd2, 7, q, -1, 1);
        settle("gig64");

        // 100M nibbles A,B,C,D -> 0xBA, 0xDC
        q = {};
        q.push_back(8'h0A); q.push_back(8'h0B); q.push_back(8'h0C); q.push_back(8'h0D);
        send_frame(2'd1, 15, q, -1, 1);
        settle("fe_abcd");

        // 1000M, er on byte 10 of 20
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        send_frame(2'd2, 7, q, 9, 2);
        settle("gig_er");

        // bad SFD then a good frame
        send_bad(2'd2, 2, 1'b0, 5, 1);
        settle("bad_sfd");
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
        send_frame(2'd2, 7, q, -1, 1);
        settle("after_bad");

        // 10M odd nibble count
        q = {};
        q.push_back(8'h03); q.push_back(8'h07); q.push_back(8'h09);
        send_frame(2'd0, 15, q, -1, 1);
        settle("odd_nib");

        // reset mid-DATA of a 1000M frame; trailing dv-high goes to DROP
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, 2'd2);
        drive(1'b1, 1'b0, 8'hD5, 2'd2);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back('{data: 8'h80 + 8'(i), last: 1'b0, err: 1'b0});
            drive(1'b1, 1'b0, 8'h80 + 8'(i), 2'd2);
        end
        drive(1'b1, 1'b0, 8'h8C, 2'd2);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        mon_last = 8'h00;
        m_frame  = 0;
        m_err    = 0;
        check("midreset_outs", {22'd0, v_o, data_o, last_o}, 32'd0);
        check("midreset_err", 32'(err_o), 32'd0);
        check("midreset_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check("midreset_err_cnt", 32'(err_cnt_o), 32'd0);
        drive(1'b1, 1'b0, 8'h0B, 2'd2);
        reset_i = 1'b0;
        drive(1'b1, 1'b0, 8'h0C, 2'd2);
        drive(1'b1, 1'b0, 8'h0D, 2'd2);
        m_err = 1;
        settle("post_reset_drop");

        // back-to-back frames with a single idle cycle between them
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        send_frame(2'd2, 3, q, -1, 1);
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'($urandom));
        send_frame(2'd3, 1, q, -1, 1);
        settle("b2b");
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        send_frame(2'd1, 4, q, -1, 1);
        q = {};
        q.push_back(8'h42);
        send_frame(2'd2, 2, q, -1, 1);
        settle("b2b_mixed");

        // preamble abandoned, er in preamble, bad value straight from IDLE, empty frame
        send_runt(2'd2, 3, 1);
        send_runt(2'd0, 5, 1);
        settle("runt");
        send_bad(2'd1, 3, 1'b1, 2, 1);
        send_bad(2'd2, 0, 1'b0, 3, 1);
        send_bad(2'd0, 0, 1'b0, 0, 1);
        q = {};
        send_frame(2'd2, 4, q, -1, 1);
        settle("drops");

        // randomized traffic, long enough to saturate both counters
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            spd  = 2'($urandom_range(0, 3));
            if (kind <= 5) begin
                len = spd[1] ? $urandom_range(0, 16) : $urandom_range(0, 25);
                q = {};
                for (int i = 0; i < len; i++) q.push_back(8'($urandom));
                send_frame(spd, spd[1] ? $urandom_range(1, 7) : $urandom_range(1, 15), q,
                           ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1,
                           $urandom_range(1, 3));
            end else if (kind <= 7) begin
                send_bad(spd, $urandom_range(0, 4), 1'b0, $urandom_range(0, 6), $urandom_range(1, 3));
            end else if (kind == 8) begin
                send_runt(spd, $urandom_range(1, 6), $urandom_range(1, 3));
            end else begin
                send_bad(spd, $urandom_range(1, 4), 1'b1, $urandom_range(0, 6), $urandom_range(1, 3));
            end
            settle("rand");
        end

        // one more good frame with the frame counter at its ceiling
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        send_frame(2'd2, 7, q, -1, 1);
        settle("saturated");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
